ssd_scan: RTL and testbench
===========================

SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clocks per digit slot (legal >= 4).
REQ-003 Parameter BLANK_CYC, default 4, inter-digit blanking clocks at start of each slot (legal 1..REFRESH_DIV-2).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, 1 = Seg/Dp lit when 0.
REQ-005 Parameter DIG_ACTIVE_LOW, default 1, 1 = DigitEn selects when 0.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 Enable  input  1  1 = scanning; 0 = display dark.
REQ-009 LoadValid  input  1  new value offered.
REQ-010 LoadReady  output  1  staging register free.
REQ-011 HexIn  input  4*NUM_DIGITS  nibble i drives digit i (digit 0 = least significant).
REQ-012 DpIn  input  NUM_DIGITS  decimal point per digit, captured with HexIn.
REQ-013 Seg  output  7  segments {G,F,E,D,C,B,A}, bit 0 = A.
REQ-014 Dp  output  1  decimal point of the active digit.
REQ-015 DigitEn  output  NUM_DIGITS  one-hot digit select.

Function
REQ-016 Encoding (lit=1, GFEDCBA hex) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; polarity parameters invert afterwards.
REQ-017 Prescaler counts 0..REFRESH_DIV-1 and wraps; on wrap digit index increments, wrapping NUM_DIGITS-1 -> 0.
REQ-018 Frame end = index NUM_DIGITS-1 and prescaler REFRESH_DIV-1.
REQ-019 While prescaler < BLANK_CYC all DigitEn inactive and Seg/Dp unlit; otherwise DigitEn[index] active only, Seg/Dp show display nibble/bit [index].
REQ-020 Seg, Dp, DigitEn SHALL be registered: they reflect prescaler/index of the previous clock (1-cycle latency).
REQ-021 Handshake: transfer when LoadValid && LoadReady; HexIn/DpIn captured into staging, LoadReady deasserts next cycle.
REQ-022 Staging copies to display register at the first frame end where pending was already set at the start of that cycle; LoadReady reasserts the following cycle.
REQ-023 Transfer coinciding with a frame end SHALL wait for the next frame end (no tearing mid-frame).
REQ-024 Enable=0: prescaler and index held at 0, outputs inactive, every cycle is treated as frame end for pending copy; handshake stays operational.
REQ-025 Enable 0->1: scanning restarts at digit 0, prescaler 0, beginning with the blanking window.

Reset
REQ-026 rst_n low SHALL immediately force: prescaler 0, index 0, display and staging registers 0, pending 0, DigitEn all inactive, Seg/Dp unlit.
REQ-027 LoadReady SHALL be 1 during and after reset; reset mid-transfer discards staging.
REQ-028 Release is synchronised by the system; first scan slot begins on first clock with rst_n high and Enable 1.

Configuration
REQ-029 Macro SSD_LZB_EN defined: digits above the most significant nonzero display nibble show unlit Seg (Dp still honoured, DigitEn still scanned); digit 0 always shown, so value 0 shows one "0".
REQ-030 Macro SSD_LZB_EN undefined: every digit shows its nibble including leading zeros; no blanking logic present.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, both polarities 0)
REQ-031 Reset then Enable=1, no load -> DigitEn cycles 0001,0010,0100,1000 each lit 6 of 8 clocks, Seg=3F, repeating every 32 clocks.
REQ-032 Load HexIn=0x1A2F mid-frame -> LoadReady 0 next clock; display changes only at frame end; digit0..3 Seg = 71,5B,77,06; LoadReady 1 one clock after copy.
REQ-033 LoadValid asserted on the frame-end clock -> value appears one frame (32 clocks) later, not immediately.
REQ-034 Enable=0 with pending load -> DigitEn 0000, copy next clock; Enable=1 -> scan restarts at digit 0 after 2 blank clocks.
REQ-035 rst_n pulsed low mid-slot -> outputs inactive asynchronously, LoadReady 1, display returns to 0000.
REQ-036 SSD_LZB_EN defined, HexIn=0x0040 -> digits 3,2 Seg=00, digit1=66, digit0=3F; HexIn=0x0000 -> only digit0 lit 3F.

Source files
------------

// File: rtl/ssd_scan.sv
// -----------------------------------------------------------------------------
// ssd_scan -- multiplexed seven-segment display scanner
//
// Scans NUM_DIGITS common-select digits, one per slot of REFRESH_DIV clocks.
// The first BLANK_CYC clocks of every slot are dark so that ghosting from the
// previous digit cannot appear. A new value is accepted through a
// valid/ready staging register. It moves to the display register only at a
// frame boundary, so a frame never shows a mix of old and new digits.
//
// Optional build macro:
//   SSD_LZB_EN  - leading-zero blanking. Digits above the most significant
//                 nonzero nibble show unlit segments. Dp is still shown and
//                 DigitEn is still scanned. Digit 0 is always shown.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   Enable     1 = scanning, 0 = display dark (prescaler/index held at 0)
//   LoadValid  new value offered on HexIn/DpIn
//   LoadReady  staging register free (registered)
//   HexIn      nibble i drives digit i, digit 0 least significant
//   DpIn       decimal point per digit, captured with HexIn
//   Seg        segments {G,F,E,D,C,B,A} of the active digit (registered)
//   Dp         decimal point of the active digit (registered)
//   DigitEn    one-hot digit select (registered)
//
// Load handshake states:
//   state      | meaning
//   LD_FREE    | staging empty, LoadReady high, accepting a new value
//   LD_PENDING | staging holds a value waiting for the next frame end
// -----------------------------------------------------------------------------
module ssd_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int BLANK_CYC      = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    Enable,
   input  logic                    LoadValid,
   output logic                    LoadReady,
   input  logic [4*NUM_DIGITS-1:0] HexIn,
   input  logic [NUM_DIGITS-1:0]   DpIn,
   output logic [6:0]              Seg,
   output logic                    Dp,
   output logic [NUM_DIGITS-1:0]   DigitEn
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   // Polarity is applied as an XOR mask on the lit=1 encoding.
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

   typedef enum logic {
      LD_FREE    = 1'b0,
      LD_PENDING = 1'b1
   } ld_state_t;

   ld_state_t ld_state;

   logic [CW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] stage_hex;
   logic [NUM_DIGITS-1:0]   stage_dp;
   logic [4*NUM_DIGITS-1:0] disp_hex;
   logic [NUM_DIGITS-1:0]   disp_dp;

   logic                    frame_end;
   logic                    in_blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic [6:0]              cur_seg;
   logic [NUM_DIGITS-1:0]   cur_sel;
   logic                    blank_lead;

   // Hex to segment encoding, lit = 1, bit 0 = segment A.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // A disabled display counts as a frame end on every cycle, so a pending
   // value is never stuck behind a stopped scan.
   assign frame_end = !Enable || ((idx == IDX_LAST) && (presc == CNT_LAST));
   assign in_blank  = (presc < CNT_BLANK);

   // ---------------------------------------------------------------- scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (!Enable) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == CNT_LAST) begin
         presc <= '0;
         idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // ------------------------------------------------------- load handshake
   // The value can only move to the display register from LD_PENDING. A
   // transfer that lands on a frame-end cycle therefore waits a full frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_state  <= LD_FREE;
         LoadReady <= 1'b1;
         stage_hex <= '0;
         stage_dp  <= '0;
         disp_hex  <= '0;
         disp_dp   <= '0;
      end else begin
         case (ld_state)
            LD_FREE: begin
               if (LoadValid) begin
                  stage_hex <= HexIn;
                  stage_dp  <= DpIn;
                  ld_state  <= LD_PENDING;
                  LoadReady <= 1'b0;
               end
            end
            LD_PENDING: begin
               if (frame_end) begin
                  disp_hex  <= stage_hex;
                  disp_dp   <= stage_dp;
                  ld_state  <= LD_FREE;
                  LoadReady <= 1'b1;
               end
            end
            default: begin
               ld_state  <= LD_FREE;
               LoadReady <= 1'b1;
            end
         endcase
      end
   end

   // ----------------------------------------------------- digit selection
   always_comb begin
      cur_sel      = '0;
      cur_sel[idx] = 1'b1;
   end

   assign cur_nib = disp_hex[{idx, 2'b00} +: 4];
   assign cur_dp  = disp_dp[idx];

`ifdef SSD_LZB_EN
   // Position of the most significant nonzero nibble. It stays 0 when the
   // whole value is zero, so digit 0 still shows a single "0".
   logic [IW-1:0] msd;

   always_comb begin
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (disp_hex[4*i +: 4] != 4'h0) begin
            msd = IW'(i);
         end
      end
   end

   assign blank_lead = (idx > msd);
`else
   assign blank_lead = 1'b0;
`endif

   assign cur_seg = blank_lead ? 7'h00 : hex_to_seg(cur_nib);

   // ------------------------------------------------------ output register
   // Outputs describe the prescaler/index of the previous clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Seg     <= {7{SEG_INV}};
         Dp      <= SEG_INV;
         DigitEn <= {NUM_DIGITS{DIG_INV}};
      end else if (!Enable || in_blank) begin
         Seg     <= {7{SEG_INV}};
         Dp      <= SEG_INV;
         DigitEn <= {NUM_DIGITS{DIG_INV}};
      end else begin
         Seg     <= cur_seg ^ {7{SEG_INV}};
         Dp      <= cur_dp ^ SEG_INV;
         DigitEn <= cur_sel ^ {NUM_DIGITS{DIG_INV}};
      end
   end

endmodule

// File: tb/tb_ssd_scan.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan -- bench for ssd_scan with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYC=2 and both polarities active-high.
// The reference model tracks time as "clocks since scanning started" and
// derives slot and phase from that count with division. Every clock the model
// output is compared with the DUT. A table of known values checks the
// per-digit segment encoding. Hand-written sequences cover the frame-end
// handshake, Enable low/high and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_ssd_scan;

   localparam int ND    = 4;
   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        Enable = 1'b0;
   logic        LoadValid = 1'b0;
   logic        LoadReady;
   logic [15:0] HexIn = 16'h0;
   logic [3:0]  DpIn = 4'h0;
   logic [6:0]  Seg;
   logic        Dp;
   logic [3:0]  DigitEn;

   ssd_scan #(
      .NUM_DIGITS    (ND),
      .REFRESH_DIV   (RD),
      .BLANK_CYC     (BC),
      .SEG_ACTIVE_LOW(0),
      .DIG_ACTIVE_LOW(0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Enable   (Enable),
      .LoadValid(LoadValid),
      .LoadReady(LoadReady),
      .HexIn    (HexIn),
      .DpIn     (DpIn),
      .Seg      (Seg),
      .Dp       (Dp),
      .DigitEn  (DigitEn)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int          m_t;
   bit          m_pending;
   logic [15:0] m_disp, m_stage;
   logic [3:0]  m_dp, m_sdp;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_dig;
   logic        e_rdy;

   logic [6:0]  cap_seg [4];
   logic        cap_dp  [4];

   typedef struct {
      logic [15:0] hex;
      logic [3:0]  dp;
      logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
   } vec_t;

   vec_t vecs [4];

   function automatic logic [6:0] enc(input int v);
      case (v)
         0:  return 7'h3F;  1:  return 7'h06;  2:  return 7'h5B;  3:  return 7'h4F;
         4:  return 7'h66;  5:  return 7'h6D;  6:  return 7'h7D;  7:  return 7'h07;
         8:  return 7'h7F;  9:  return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
         12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   function automatic int lead_digit(input logic [15:0] v);
      int m = 0;
      for (int i = 1; i < ND; i++) begin
         if (((v >> (4 * i)) & 16'hF) != 16'h0) m = i;
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = 0; m_pending = 0; m_disp = 16'h0; m_stage = 16'h0; m_dp = 4'h0; m_sdp = 4'h0;
      e_seg = 7'h00; e_dp = 1'b0; e_dig = 4'h0; e_rdy = 1'b1;
   endtask

   // One clock: predict from the inputs now applied, clock, compare.
   task automatic tick();
      int  slot, ph, nib;
      bit  fe;
      ph   = m_t % RD;
      slot = (m_t / RD) % ND;
      if (!Enable || ph < BC) begin
         e_dig = 4'h0; e_seg = 7'h00; e_dp = 1'b0;
      end else begin
         nib   = int'((m_disp >> (4 * slot)) & 16'hF);
         e_dig = 4'(1 << slot);
         e_seg = enc(nib);
         e_dp  = m_dp[slot];
`ifdef SSD_LZB_EN
         if (slot > lead_digit(m_disp)) e_seg = 7'h00;
`endif
      end
      fe = !Enable || ((m_t % FRAME) == FRAME - 1);
      if (m_pending && fe) begin
         m_disp = m_stage; m_dp = m_sdp; m_pending = 0;
      end else if (LoadValid && !m_pending) begin
         m_stage = HexIn; m_sdp = DpIn; m_pending = 1;
      end
      m_t   = Enable ? m_t + 1 : 0;
      e_rdy = !m_pending;
      @(posedge clk);
      #1;
      check("outputs{rdy,dig,dp,seg}", 32'({LoadReady, DigitEn, Dp, Seg}),
            32'({e_rdy, e_dig, e_dp, e_seg}));
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!LoadReady && n < 100) begin
         tick();
         n++;
      end
      if (!LoadReady) begin
         errors++;
         $display("FAIL %s: LoadReady still %b after %0d clocks, required 1", name, LoadReady, n);
      end
   endtask

   // Record the segments/dp each digit shows over one full frame.
   task automatic collect();
      for (int i = 0; i < ND; i++) begin
         cap_seg[i] = 7'h7F;
         cap_dp[i]  = 1'b0;
      end
      for (int k = 0; k < FRAME; k++) begin
         tick();
         for (int i = 0; i < ND; i++) begin
            if (DigitEn == 4'(1 << i)) begin
               cap_seg[i] = Seg;
               cap_dp[i]  = Dp;
            end
         end
      end
   endtask

   task automatic load_and_show(input logic [15:0] h, input logic [3:0] d);
      wait_ready("ready_before_load");
      LoadValid = 1'b1; HexIn = h; DpIn = d;
      tick();
      LoadValid = 1'b0;
      HexIn = 16'($urandom); DpIn = 4'($urandom);
      wait_ready("ready_after_copy");
      collect();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lit_cnt [4];
      int low;

      vecs[0] = '{16'h1A2F, 4'b0001, {7'h06, 7'h77, 7'h5B, 7'h71}};
      vecs[1] = '{16'h8390, 4'b1010, {7'h7F, 7'h4F, 7'h6F, 7'h3F}};
      vecs[2] = '{16'hC4E6, 4'b0100, {7'h39, 7'h66, 7'h79, 7'h7D}};
      vecs[3] = '{16'h7DB5, 4'b1111, {7'h07, 7'h5E, 7'h7C, 7'h6D}};

      // Asynchronous reset assertion.
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("reset_outputs", 32'({LoadReady, DigitEn, Dp, Seg}), 32'({1'b1, 4'h0, 1'b0, 7'h00}));
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      Enable = 1'b1;

      // Idle scan: each digit lit 6 of 8 clocks, two frames.
      for (int i = 0; i < ND; i++) lit_cnt[i] = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick();
         for (int i = 0; i < ND; i++) if (DigitEn == 4'(1 << i) && Seg == 7'h3F) lit_cnt[i]++;
      end
      for (int i = 0; i < ND; i++) check($sformatf("lit_count_digit%0d", i), 32'(lit_cnt[i]), 32'd12);

      // Table of known values: encoding and decimal points per digit.
      for (int v = 0; v < 4; v++) begin
         load_and_show(vecs[v].hex, vecs[v].dp);
         for (int i = 0; i < ND; i++) begin
            check($sformatf("vec%0d_seg_digit%0d", v, i), 32'(cap_seg[i]), 32'(vecs[v].segs[7*i +: 7]));
            check($sformatf("vec%0d_dp_digit%0d", v, i), 32'(cap_dp[i]), 32'(vecs[v].dp[i]));
         end
      end

      // Transfer on the frame-end clock waits a whole frame.
      wait_ready("ready_before_fe_load");
      while ((m_t % FRAME) != FRAME - 1) tick();
      LoadValid = 1'b1; HexIn = 16'h5555; DpIn = 4'h0;
      tick();
      LoadValid = 1'b0;
      low = LoadReady ? 0 : 1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!LoadReady) low++;
         else break;
      end
      check("frame_end_load_ready_low_clocks", 32'(low), 32'd32);

      // Enable low with a pending value: dark, copy next clock, restart at digit 0.
      tick(); tick(); tick();
      LoadValid = 1'b1; HexIn = 16'h9876; DpIn = 4'h0;
      tick();
      LoadValid = 1'b0;
      Enable = 1'b0;
      tick();
      check("disable_copy_ready_dark", 32'({LoadReady, DigitEn}), 32'({1'b1, 4'h0}));
      Enable = 1'b1;
      tick();
      check("restart_blank0", 32'(DigitEn), 32'h0);
      tick();
      check("restart_blank1", 32'(DigitEn), 32'h0);
      tick();
      check("restart_digit0", 32'({DigitEn, Seg}), 32'({4'b0001, 7'h7D}));

      // Randomised traffic with occasional Enable flips.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 15) == 0) Enable = ~Enable;
         LoadValid = ($urandom_range(0, 3) == 0);
         HexIn     = 16'($urandom);
         DpIn      = 4'($urandom);
         tick();
      end
      LoadValid = 1'b0;
      Enable    = 1'b1;

      // Reset mid-slot with a value pending.
      wait_ready("ready_before_reset");
      LoadValid = 1'b1; HexIn = 16'hABCD; DpIn = 4'hF;
      tick();
      LoadValid = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("midslot_reset_async", 32'({LoadReady, DigitEn, Dp, Seg}), 32'({1'b1, 4'h0, 1'b0, 7'h00}));
      model_reset();
      rst_n = 1'b1;
      collect();
      for (int i = 0; i < ND; i++) check($sformatf("post_reset_digit%0d", i), 32'(cap_seg[i]), 32'h3F);

`ifdef SSD_LZB_EN
      load_and_show(16'h0040, 4'h0);
      check("lzb_0040_d3", 32'(cap_seg[3]), 32'h00);
      check("lzb_0040_d2", 32'(cap_seg[2]), 32'h00);
      check("lzb_0040_d1", 32'(cap_seg[1]), 32'h66);
      check("lzb_0040_d0", 32'(cap_seg[0]), 32'h3F);
      load_and_show(16'h0000, 4'h0);
      check("lzb_0000_d3", 32'(cap_seg[3]), 32'h00);
      check("lzb_0000_d2", 32'(cap_seg[2]), 32'h00);
      check("lzb_0000_d1", 32'(cap_seg[1]), 32'h00);
      check("lzb_0000_d0", 32'(cap_seg[0]), 32'h3F);
`else
      load_and_show(16'h0040, 4'h0);
      check("nolzb_0040_d3", 32'(cap_seg[3]), 32'h3F);
      check("nolzb_0040_d1", 32'(cap_seg[1]), 32'h66);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
